// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl -- AES-128 key expansion controller.
//
// Accepts a 128-bit cipher key, expands it into the 11 AES-128 round keys
// (one full round key per clock, combinational S-box, no extra pipeline),
// stores them, and serves registered single-cycle-latency reads.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   key_in      cipher key, [127:96] is word w0
//   key_valid   key_in valid this cycle
//   key_ready   block can accept a key (IDLE or DONE)
//   keys_ready  all 11 round keys stored and readable (DONE)
//   rd_en       round-key read request
//   rd_idx      round-key index 0..10
//   rd_data     registered read data (0 unless rd_vld)
//   rd_vld      rd_data valid this cycle
//   rd_err      previous-cycle read was rejected
//   zeroize     wipe all key state (only with KEY_SCHED_ZEROIZE_EN)
//
// Build option: define KEY_SCHED_ZEROIZE_EN to add the zeroize port.
module key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         keys_ready,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_data,
  output logic         rd_vld,
  output logic         rd_err
`ifdef KEY_SCHED_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     round_cnt;
  logic [7:0]     rcon;
  logic [127:0]   rk [0:10];
  logic [127:0]   last_key;
  logic [127:0]   next_key;
  logic [127:0]   rd_sel;
  logic [31:0]    rot_w;
  logic [7:0]     sub_b [0:3];
  logic           zero_req;
  logic           accept;
  logic           rd_legal;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by
  // the AES affine transform, instead of a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // RotWord of w3 feeds four parallel S-boxes.
  assign rot_w = {last_key[23:0], last_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sub_b[g] = sbox(rot_w[8*g +: 8]);
  end

  always_comb begin
    next_key[127:96] = last_key[127:96] ^ {sub_b[3], sub_b[2], sub_b[1], sub_b[0]}
                       ^ {rcon, 24'h0};
    next_key[95:64]  = last_key[95:64] ^ next_key[127:96];
    next_key[63:32]  = last_key[63:32] ^ next_key[95:64];
    next_key[31:0]   = last_key[31:0]  ^ next_key[63:32];
  end

  assign accept = key_valid && key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    key_ready  = (state != EXPAND);
    keys_ready = (state == DONE);
    case (state)
      IDLE:    if (accept) state_nxt = EXPAND;
      EXPAND:  if (round_cnt == 4'd10) state_nxt = DONE;
      DONE:    if (accept) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
    if (zero_req) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt <= '0;
      rcon      <= 8'h01;
      last_key  <= '0;
      for (int unsigned i = 0; i < 11; i++) rk[i] <= '0;
    end else if (zero_req) begin
      round_cnt <= '0;
      rcon      <= '0;
      last_key  <= '0;
      for (int unsigned i = 0; i < 11; i++) rk[i] <= '0;
    end else if (accept) begin
      rk[0]     <= key_in;
      last_key  <= key_in;
      round_cnt <= 4'd1;
      rcon      <= 8'h01;
    end else if (state == EXPAND) begin
      for (int unsigned i = 1; i < 11; i++) begin
        if (round_cnt == 4'(i)) rk[i] <= next_key;
      end
      last_key <= next_key;
      rcon     <= xtime(rcon);
      if (round_cnt != 4'd10) round_cnt <= round_cnt + 4'd1;
    end
  end

  // Reads sample keys_ready and the key array before this edge's update, so
  // a read coinciding with a rekey returns the old key.
  assign rd_legal = keys_ready && (rd_idx <= 4'd10);

  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < 11; i++) begin
      if (rd_idx == 4'(i)) rd_sel = rk[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      rd_vld  <= rd_en && rd_legal && !zero_req;
      rd_err  <= rd_en && (!rd_legal || zero_req);
      rd_data <= (rd_en && rd_legal && !zero_req) ? rd_sel : '0;
    end
  end

endmodule
